rc5_session_ctrl: RTL and testbench

//  Host-side sequencer for the RC5 core's key-write and start/done interface.

---
 rtl/rc5_pkg.sv | 27 ++
 rtl/rc5_key_serializer.sv | 66 ++++++
 rtl/rc5_session_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rc5_session_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc5_pkg.sv
// rc5_pkg
//   Shared definitions for the RC5 host-side session controller.
//   - sessionStateT : controller state encoding
//   - MODE_CIPHER / MODE_DECIPHER : values of the request mode bit
//   - DEFAULT_W / DEFAULT_B : default word size (bits) and key length (bytes)
//   - PW / QW : RC5-32 magic constants (used by core models and key expansion)
package rc5_pkg;

  localparam int DEFAULT_W = 32;
  localparam int DEFAULT_B = 16;

  localparam logic [31:0] PW = 32'hB7E15163;
  localparam logic [31:0] QW = 32'h9E3779B9;

  localparam logic MODE_CIPHER   = 1'b0;
  localparam logic MODE_DECIPHER = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARMED = 3'd2,
    RUN   = 3'd3,
    RESP  = 3'd4,
    DRAIN = 3'd5
  } sessionStateT;

endpackage

// File: rtl/rc5_key_serializer.sv
// rc5_key_serializer
//   Latches a B-byte key and writes it into the core key RAM one byte per
//   cycle, address 0 first.
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   iLoad         latch iKey and start writing on the following cycle
//   iKey          key, byte i = iKey[8*i+:8]
//   oKey_sub_i    byte currently written (0 when idle)
//   oKey_address  address currently written (0 when idle)
//   oWen          write enable, high for exactly B cycles per load
//   oLast         high on the cycle that writes address B-1
module rc5_key_serializer
  import rc5_pkg::*;
#(
  parameter int B        = DEFAULT_B,
  parameter int B_LENGTH = $clog2(B)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iLoad,
  input  logic [8*B-1:0]      iKey,
  output logic [7:0]          oKey_sub_i,
  output logic [B_LENGTH-1:0] oKey_address,
  output logic                oWen,
  output logic                oLast
);

  localparam logic [B_LENGTH-1:0] LAST_ADDR = B_LENGTH'(B - 1);

  logic [8*B-1:0]      keyReg;
  logic [B_LENGTH-1:0] addrReg;
  logic                busyReg;
  logic [7:0]          keyBytes [B];

  generate
    for (genvar gi = 0; gi < B; gi++) begin : genKeyBytes
      assign keyBytes[gi] = keyReg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyReg  <= '0;
      addrReg <= '0;
      busyReg <= 1'b0;
    end else if (iLoad) begin
      keyReg  <= iKey;
      addrReg <= '0;
      busyReg <= 1'b1;
    end else if (busyReg) begin
      // Return the address to 0 after the final byte so idle outputs are quiet.
      if (addrReg == LAST_ADDR) begin
        busyReg <= 1'b0;
        addrReg <= '0;
      end else begin
        addrReg <= addrReg + 1'b1;
      end
    end
  end

  assign oWen         = busyReg;
  assign oKey_address = addrReg;
  assign oKey_sub_i   = busyReg ? keyBytes[addrReg] : 8'h00;
  assign oLast        = busyReg && (addrReg == LAST_ADDR);

endmodule

// File: rtl/rc5_session_ctrl.sv
// rc5_session_ctrl
//   Host-side sequencer for the RC5 core: loads the key into the core key
//   RAM, then runs cipher/decipher requests with a level start/done handshake
//   and hands the result back over valid/ready.
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   iKeyValid/oKeyReady/iKey    key offer (byte i = iKey[8*i+:8])
//   iReqValid/oReqReady         block request offer; iMode 0=cipher 1=decipher
//   iA, iB                      request block halves
//   oKey_sub_i/oKey_address/oWen  key RAM byte write port to the core
//   oStartCipher/oStartDecipher level starts to the core
//   oA, oB                      block presented to the core
//   iDoneCipher/iDoneDecipher   level dones from the core
//   iA_cipher..iB_decipher      core results
//   oRespValid/iRespReady       response handshake, oRespA/oRespB result
//   oKeyLoaded                  a complete key is resident in the core
// Build option
//   RC5_KEY_SKIP_EN : remember the last fully loaded key; re-offering it in
//   ARMED is accepted in one cycle with no RAM writes.
module rc5_session_ctrl
  import rc5_pkg::*;
#(
  parameter int W        = DEFAULT_W,
  parameter int B        = DEFAULT_B,
  parameter int B_LENGTH = $clog2(B)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iKeyValid,
  output logic                oKeyReady,
  input  logic [8*B-1:0]      iKey,
  input  logic                iReqValid,
  output logic                oReqReady,
  input  logic                iMode,
  input  logic [W-1:0]        iA,
  input  logic [W-1:0]        iB,
  output logic [7:0]          oKey_sub_i,
  output logic [B_LENGTH-1:0] oKey_address,
  output logic                oWen,
  output logic                oStartCipher,
  output logic                oStartDecipher,
  output logic [W-1:0]        oA,
  output logic [W-1:0]        oB,
  input  logic                iDoneCipher,
  input  logic                iDoneDecipher,
  input  logic [W-1:0]        iA_cipher,
  input  logic [W-1:0]        iB_cipher,
  input  logic [W-1:0]        iA_decipher,
  input  logic [W-1:0]        iB_decipher,
  output logic                oRespValid,
  input  logic                iRespReady,
  output logic [W-1:0]        oRespA,
  output logic [W-1:0]        oRespB,
  output logic                oKeyLoaded
);

  sessionStateT stateReg, stateNext;

  logic         modeReg;
  logic [W-1:0] aReg, bReg;
  logic [W-1:0] respAReg, respBReg;
  logic         keyLoadedReg;

  logic         keyAccept, reqAccept, loadStart, skipHit, lastByte;
  logic         doneSel;
  logic [W-1:0] resASel, resBSel;

  // Ready outputs held low while reset is asserted so nothing handshakes then.
  // In ARMED a simultaneous key offer wins, so the request is refused.
  assign oKeyReady = !rst && (stateReg == IDLE || stateReg == ARMED);
  assign oReqReady = !rst && (stateReg == ARMED) && !iKeyValid;
  assign keyAccept = iKeyValid && oKeyReady;
  assign reqAccept = iReqValid && oReqReady;

  // Only the done/result of the running mode is ever looked at.
  assign doneSel = (modeReg == MODE_DECIPHER) ? iDoneDecipher : iDoneCipher;
  assign resASel = (modeReg == MODE_DECIPHER) ? iA_decipher   : iA_cipher;
  assign resBSel = (modeReg == MODE_DECIPHER) ? iB_decipher   : iB_cipher;

`ifdef RC5_KEY_SKIP_EN
  // Updated at every load start; it only counts as resident once
  // keyLoadedReg is set, i.e. after that load has written all B bytes.
  logic [8*B-1:0] lastKeyReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastKeyReg <= '0;
    end else if (loadStart) begin
      lastKeyReg <= iKey;
    end
  end

  assign skipHit = (stateReg == ARMED) && keyLoadedReg && (iKey == lastKeyReg);
`else
  assign skipHit = 1'b0;
`endif

  rc5_key_serializer #(
    .B        (B),
    .B_LENGTH (B_LENGTH)
  ) uKeySer (
    .clk          (clk),
    .rst          (rst),
    .iLoad        (loadStart),
    .iKey         (iKey),
    .oKey_sub_i   (oKey_sub_i),
    .oKey_address (oKey_address),
    .oWen         (oWen),
    .oLast        (lastByte)
  );

  always_comb begin
    stateNext      = stateReg;
    loadStart      = 1'b0;
    oStartCipher   = 1'b0;
    oStartDecipher = 1'b0;
    oRespValid     = 1'b0;
    case (stateReg)
      IDLE: begin
        if (keyAccept) begin
          loadStart = 1'b1;
          stateNext = LOAD;
        end
      end
      LOAD: begin
        if (lastByte) stateNext = ARMED;
      end
      ARMED: begin
        if (keyAccept) begin
          if (!skipHit) begin
            loadStart = 1'b1;
            stateNext = LOAD;
          end
        end else if (reqAccept) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        oStartCipher   = (modeReg == MODE_CIPHER);
        oStartDecipher = (modeReg == MODE_DECIPHER);
        if (doneSel) stateNext = RESP;
      end
      RESP: begin
        oRespValid = 1'b1;
        if (iRespReady) stateNext = DRAIN;
      end
      DRAIN: begin
        // Wait out the level done so the next request cannot see it.
        if (!doneSel) stateNext = ARMED;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg     <= IDLE;
      modeReg      <= MODE_CIPHER;
      aReg         <= '0;
      bReg         <= '0;
      respAReg     <= '0;
      respBReg     <= '0;
      keyLoadedReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (reqAccept) begin
        modeReg <= iMode;
        aReg    <= iA;
        bReg    <= iB;
      end
      if (stateReg == RUN && doneSel) begin
        respAReg <= resASel;
        respBReg <= resBSel;
      end
      if (loadStart) begin
        keyLoadedReg <= 1'b0;
      end else if (stateReg == LOAD && lastByte) begin
        keyLoadedReg <= 1'b1;
      end
    end
  end

  assign oA         = aReg;
  assign oB         = bReg;
  assign oRespA     = respAReg;
  assign oRespB     = respBReg;
  assign oKeyLoaded = keyLoadedReg;

endmodule

// File: tb/tb_rc5_session_ctrl.sv
`timescale 1ns/1ps
module tb_rc5_session_ctrl;
  import rc5_pkg::*;

  localparam int W  = 32;
  localparam int B  = 16;
  localparam int BL = 4;

  localparam logic [8*B-1:0] K1 = 128'h91CEA91001A5556351B241BE19465F91;
  localparam logic [8*B-1:0] K3 = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic clk = 1'b0;
  logic rst;
  logic iKeyValid, oKeyReady, iReqValid, oReqReady, iMode;
  logic [8*B-1:0] iKey;
  logic [W-1:0] iA, iB, oA, oB, oRespA, oRespB;
  logic [7:0] oKey_sub_i;
  logic [BL-1:0] oKey_address;
  logic oWen, oStartCipher, oStartDecipher, iDoneCipher, iDoneDecipher;
  logic [W-1:0] iA_cipher, iB_cipher, iA_decipher, iB_decipher;
  logic oRespValid, iRespReady, oKeyLoaded;

  always #5 clk = ~clk;

  rc5_session_ctrl #(.W(W), .B(B), .B_LENGTH(BL)) dut (
    .clk(clk), .rst(rst),
    .iKeyValid(iKeyValid), .oKeyReady(oKeyReady), .iKey(iKey),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iMode(iMode), .iA(iA), .iB(iB),
    .oKey_sub_i(oKey_sub_i), .oKey_address(oKey_address), .oWen(oWen),
    .oStartCipher(oStartCipher), .oStartDecipher(oStartDecipher), .oA(oA), .oB(oB),
    .iDoneCipher(iDoneCipher), .iDoneDecipher(iDoneDecipher),
    .iA_cipher(iA_cipher), .iB_cipher(iB_cipher),
    .iA_decipher(iA_decipher), .iB_decipher(iB_decipher),
    .oRespValid(oRespValid), .iRespReady(iRespReady),
    .oRespA(oRespA), .oRespB(oRespB), .oKeyLoaded(oKeyLoaded)
  );

  int nChecks = 0;
  int nFails  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference cipher used by the core stand-in and by the expected responses.
  function automatic logic [2*W-1:0] coreFn(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    if (m == MODE_DECIPHER) return {a ^ PW, b - QW};
    return {a ^ PW, b + QW};
  endfunction

  // ---------------- core stand-in: level done after a random latency ----------------
  logic         coreDone [2];
  logic [W-1:0] coreA [2];
  logic [W-1:0] coreB [2];
  int coreCnt [2];
  int coreLat [2];
  int coreHold [2];
  int holdMin = 0;
  int holdMax = 3;

  assign iDoneCipher   = coreDone[0];
  assign iDoneDecipher = coreDone[1];
  assign iA_cipher     = coreA[0];
  assign iB_cipher     = coreB[0];
  assign iA_decipher   = coreA[1];
  assign iB_decipher   = coreB[1];

  initial begin
    for (int k = 0; k < 2; k++) begin
      coreDone[k] = 1'b0; coreA[k] = '0; coreB[k] = '0;
      coreCnt[k] = 0; coreLat[k] = 0; coreHold[k] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        logic st;
        st = (k == 0) ? oStartCipher : oStartDecipher;
        if (rst) begin
          coreDone[k] = 1'b0;
          coreCnt[k]  = 0;
        end else if (st) begin
          if (!coreDone[k]) begin
            if (coreCnt[k] >= coreLat[k]) begin
              coreDone[k] = 1'b1;
              {coreA[k], coreB[k]} = coreFn(k[0], oA, oB);
              coreHold[k] = int'($urandom_range(holdMin, holdMax));
            end else begin
              coreCnt[k]++;
            end
          end
        end else begin
          coreCnt[k] = 0;
          coreLat[k] = int'($urandom_range(0, 5));
          if (coreDone[k]) begin
            if (coreHold[k] == 0) coreDone[k] = 1'b0;
            else coreHold[k]--;
          end else begin
            coreA[k] = $urandom;
            coreB[k] = $urandom;
          end
        end
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  int mWritesLeft;
  bit mKeyLoaded, mRun, mMode, mResp, mDrain;
  logic [8*B-1:0] mKey, mLastKey;
  logic [W-1:0] mA, mB, mRespA, mRespB;
  logic [7:0] ram [B];
  int nWrites = 0;

  task automatic modelReset();
    mWritesLeft = 0; mKeyLoaded = 0; mRun = 0; mMode = 0; mResp = 0; mDrain = 0;
    mKey = '0; mLastKey = '0; mA = '0; mB = '0; mRespA = '0; mRespB = '0;
  endtask

  initial begin
    modelReset();
    forever begin
      bit eKeyReady, eReqReady, doneM, skip;
      int addr;
      @(negedge clk);
      if (rst) begin
        chk("reset_ctrl", 64'({oKeyReady, oReqReady, oWen, oStartCipher, oStartDecipher,
                               oRespValid, oKeyLoaded, oKey_address, oKey_sub_i}), 64'd0);
        chk("reset_block", {oA, oB}, 64'd0);
        chk("reset_resp", {oRespA, oRespB}, 64'd0);
        modelReset();
        continue;
      end
      eKeyReady = (mWritesLeft == 0) && !mRun && !mResp && !mDrain;
      eReqReady = eKeyReady && mKeyLoaded && !iKeyValid;
      chk("key_ready", 64'(oKeyReady), 64'(eKeyReady));
      chk("req_ready", 64'(oReqReady), 64'(eReqReady));
      chk("wen", 64'(oWen), 64'(mWritesLeft > 0));
      if (mWritesLeft > 0) begin
        addr = B - mWritesLeft;
        chk("key_addr", 64'(oKey_address), 64'(addr));
        chk("key_byte", 64'(oKey_sub_i), 64'(mKey[8*addr +: 8]));
      end
      chk("start_cipher", 64'(oStartCipher), 64'(mRun && !mMode));
      chk("start_decipher", 64'(oStartDecipher), 64'(mRun && mMode));
      if (mRun) chk("block_to_core", {oA, oB}, {mA, mB});
      chk("resp_valid", 64'(oRespValid), 64'(mResp));
      if (mResp) chk("resp_data", {oRespA, oRespB}, {mRespA, mRespB});
      chk("key_loaded", 64'(oKeyLoaded), 64'(mKeyLoaded));

      if (oWen) begin
        ram[oKey_address] = oKey_sub_i;
        nWrites++;
      end

      // advance the model over the coming clock edge
      doneM = mMode ? iDoneDecipher : iDoneCipher;
      if (mDrain && !doneM) mDrain = 0;
      if (mResp && iRespReady) begin
        mResp = 0; mDrain = 1;
        $display("resp  mode=%0d A=%h B=%h", mMode, mRespA, mRespB);
      end
      if (mRun && doneM) begin
        mRun = 0; mResp = 1;
        {mRespA, mRespB} = coreFn(mMode, mA, mB);
      end
      if (mWritesLeft > 0) begin
        mWritesLeft--;
        if (mWritesLeft == 0) begin
          mKeyLoaded = 1; mLastKey = mKey;
        end
      end
      if (iKeyValid && eKeyReady) begin
        skip = 0;
`ifdef RC5_KEY_SKIP_EN
        skip = mKeyLoaded && (iKey == mLastKey);
`endif
        $display("key   %h%s", iKey, skip ? " (resident)" : "");
        if (!skip) begin
          mKey = iKey; mWritesLeft = B; mKeyLoaded = 0;
        end
      end else if (iReqValid && eReqReady) begin
        mRun = 1; mMode = iMode; mA = iA; mB = iB;
        $display("req   mode=%0d A=%h B=%h", iMode, iA, iB);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return oRespValid;
      1: return oReqReady;
      2: return oWen && (oKey_address == 4'd7);
      3: return oKeyLoaded;
      default: return 1'b0;
    endcase
  endfunction

  task automatic waitSig(input string name, input int which, input int limit, output int n);
    n = 0;
    while (!cond(which) && n < limit) begin step(); n++; end
    chk(name, 64'(cond(which)), 64'd1);
  endtask

  task automatic sendKey(input logic [8*B-1:0] k);
    int n;
    iKeyValid = 1'b1; iKey = k; #1;
    n = 0;
    while (!oKeyReady && n < 300) begin step(); n++; end
    chk("key_accept_wait", 64'(oKeyReady), 64'd1);
    step();
    iKeyValid = 1'b0;
  endtask

  task automatic sendReq(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    iReqValid = 1'b1; iMode = m; iA = a; iB = b; #1;
    n = 0;
    while (!oReqReady && n < 300) begin step(); n++; end
    chk("req_accept_wait", 64'(oReqReady), 64'd1);
    step();
    iReqValid = 1'b0;
  endtask

  task automatic recvResp(output logic [W-1:0] ra, output logic [W-1:0] rb);
    int n;
    iRespReady = 1'b1;
    waitSig("resp_wait", 0, 300, n);
    ra = oRespA; rb = oRespB;
    step();
    iRespReady = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] ra, rb, a4, b4;
    int n;
    rst = 1'b1; iKeyValid = 0; iKey = '0; iReqValid = 0; iMode = 0; iA = '0; iB = '0; iRespReady = 0;
    step(3);
    rst = 1'b0; #1;
    chk("idle_key_ready", 64'(oKeyReady), 64'd1);
    chk("idle_req_ready", 64'(oReqReady), 64'd0);

    // 1: directed key load
    nWrites = 0;
    sendKey(K1);
    waitSig("load_done_wait", 3, 40, n);
    chk("load_write_count", 64'(nWrites), 64'd16);
    chk("ram_addr0", 64'(ram[0]), 64'h91);
    chk("ram_addr1", 64'(ram[1]), 64'h5F);
    chk("ram_addr15", 64'(ram[15]), 64'h91);

    // 2: cipher
    sendReq(MODE_CIPHER, 32'heedba521, 32'h6d8f4b15);
    recvResp(ra, rb);
    chk("cipher_result", {ra, rb}, 64'h593af442_0bc6c4ce);

    // 3: decipher back
    sendReq(MODE_DECIPHER, 32'h593af442, 32'h0bc6c4ce);
    recvResp(ra, rb);
    chk("decipher_result", {ra, rb}, 64'heedba521_6d8f4b15);

    // 4: consumer stalls 20 cycles, long done tail exercises DRAIN
    holdMin = 6; holdMax = 6;
    a4 = $urandom; b4 = $urandom;
    sendReq(MODE_CIPHER, a4, b4);
    iReqValid = 1'b1; iMode = 1'b1; iA = $urandom; iB = $urandom;
    waitSig("stall_resp_wait", 0, 300, n);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stall_valid", 64'(oRespValid), 64'd1);
      chk("stall_data", {oRespA, oRespB}, coreFn(MODE_CIPHER, a4, b4));
      chk("stall_no_req", 64'(oReqReady), 64'd0);
    end
    iReqValid = 1'b0;
    recvResp(ra, rb);
    waitSig("drain_wait", 1, 100, n);
    holdMin = 0; holdMax = 3;

    // 5: key and request in the same ARMED cycle
    iKeyValid = 1'b1; iKey = K3; iReqValid = 1'b1; iMode = 1'b0; a4 = $urandom; b4 = $urandom;
    iA = a4; iB = b4; #1;
    chk("both_key_ready", 64'(oKeyReady), 64'd1);
    chk("both_req_ready", 64'(oReqReady), 64'd0);
    step();
    iKeyValid = 1'b0;
    waitSig("stalled_req_wait", 1, 100, n);
    chk("stalled_req_cycles", 64'(n), 64'd16);
    step();
    iReqValid = 1'b0;
    recvResp(ra, rb);
    chk("after_reload_result", {ra, rb}, coreFn(MODE_CIPHER, a4, b4));

    // 6: reset in the middle of a load
    sendKey(K1);
    waitSig("addr7_wait", 2, 40, n);
    rst = 1'b1; #1;
    chk("midload_reset_ctrl", 64'({oKeyReady, oWen, oKeyLoaded, oKey_address, oKey_sub_i}), 64'd0);
    step(2);
    rst = 1'b0; #1;
    chk("post_reset_loaded", 64'(oKeyLoaded), 64'd0);
    chk("post_reset_key_ready", 64'(oKeyReady), 64'd1);
    nWrites = 0;
    sendKey(K3);
    waitSig("reload_wait", 3, 40, n);
    chk("reload_write_count", 64'(nWrites), 64'd16);
    nWrites = 0;
    sendKey(K3);
    step(20);
`ifdef RC5_KEY_SKIP_EN
    chk("reoffer_write_count", 64'(nWrites), 64'd0);
`else
    chk("reoffer_write_count", 64'(nWrites), 64'd16);
`endif

    // 7: randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        rst = 1'b1; step(2); rst = 1'b0;
      end
      iKeyValid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0: iKey = K1;
        1: iKey = K3;
        default: iKey = {$urandom, $urandom, $urandom, $urandom};
      endcase
      iReqValid  = $urandom_range(0, 1) != 0;
      iMode      = $urandom_range(0, 1) != 0;
      iA         = $urandom;
      iB         = $urandom;
      iRespReady = $urandom_range(0, 2) != 0;
      step();
    end
    iKeyValid = 0; iReqValid = 0; iRespReady = 1;
    step(40);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
